// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, memory freeze,
// plus saturating performance counters for each kind of disruption.
module hazard_ctrl #(
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemRead,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LU     = 2'd1,
        ST_FREEZE = 2'd2
    } state_e;

    localparam logic [2:0] LU_INIT = 3'(LU_BUBBLES - 1);

    state_e     state_q, state_d;
    state_e     ret_q, ret_d;
    state_e     eff_state;
    logic [2:0] rem_q, rem_d;
    logic       load_use;

    // Counter index: 0 = stall, 1 = flush, 2 = freeze.
    logic [2:0]            cnt_ev;
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

    assign load_use = ex_MemRead && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));

    // Leaving FREEZE resumes the saved state's behaviour in the same cycle.
    assign eff_state = (state_q == ST_FREEZE) ? ret_q : state_q;

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        rem_d      = rem_q;
        cnt_ev     = 3'b000;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        idex_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (dmem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
            state_d    = ST_FREEZE;
            if (state_q != ST_FREEZE) begin
                ret_d = state_q;
            end
            cnt_ev[2] = 1'b1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = ST_RUN;
            ret_d      = ST_RUN;
            rem_d      = 3'd0;
            cnt_ev[1]  = 1'b1;
        end else if ((eff_state == ST_LU) || load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            cnt_ev[0]  = 1'b1;
            if (eff_state == ST_LU) begin
                if (rem_q <= 3'd1) begin
                    state_d = ST_RUN;
                    rem_d   = 3'd0;
                end else begin
                    state_d = ST_LU;
                    rem_d   = rem_q - 3'd1;
                end
            end else if (LU_BUBBLES > 1) begin
                state_d = ST_LU;
                rem_d   = LU_INIT;
            end else begin
                state_d = ST_RUN;
                rem_d   = 3'd0;
            end
        end else begin
            state_d = ST_RUN;
        end
    end

    // Clear wins over increment; increments stop at all-ones.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            assign cnt_d[gi] = cnt_clr ? '0 :
                               (cnt_ev[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) ?
                               cnt_q[gi] + CNT_W'(1) : cnt_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            rem_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz_state   = state_q;
    assign stall_cnt  = cnt_q[0];
    assign flush_cnt  = cnt_q[1];
    assign freeze_cnt = cnt_q[2];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three parameterisations driven in parallel, checked
// every cycle against a bubble-debt model plus directed literal expectations.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_use_rs1, id_use_rs2, ex_MemRead, branch_taken, dmem_busy, cnt_clr;
    logic [4:0] id_rs1, id_rs2, ex_rd;

    logic        pcw_a, ifw_a, idw_a, iff_a, idf_a;
    logic        pcw_b, ifw_b, idw_b, iff_b, idf_b;
    logic        pcw_c, ifw_c, idw_c, iff_c, idf_c;
    logic [1:0]  hz_a, hz_b, hz_c;
    logic [31:0] sc_a, fc_a, zc_a, sc_b, fc_b, zc_b;
    logic [3:0]  sc_c, fc_c, zc_c;

    hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_MemRead(ex_MemRead), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .cnt_clr(cnt_clr), .pc_write(pcw_a), .ifid_write(ifw_a), .idex_write(idw_a),
        .ifid_flush(iff_a), .idex_flush(idf_a), .hz_state(hz_a),
        .stall_cnt(sc_a), .flush_cnt(fc_a), .freeze_cnt(zc_a));

    hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_MemRead(ex_MemRead), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .cnt_clr(cnt_clr), .pc_write(pcw_b), .ifid_write(ifw_b), .idex_write(idw_b),
        .ifid_flush(iff_b), .idex_flush(idf_b), .hz_state(hz_b),
        .stall_cnt(sc_b), .flush_cnt(fc_b), .freeze_cnt(zc_b));

    hazard_ctrl #(.LU_BUBBLES(2), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_MemRead(ex_MemRead), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .cnt_clr(cnt_clr), .pc_write(pcw_c), .ifid_write(ifw_c), .idex_write(idw_c),
        .ifid_flush(iff_c), .idex_flush(idf_c), .hz_state(hz_c),
        .stall_cnt(sc_c), .flush_cnt(fc_c), .freeze_cnt(zc_c));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int lu_of [3] = '{1, 3, 2};
    int w_of  [3] = '{32, 32, 4};

    // Model: bubbles still owed, visible state and counters per instance.
    int     owed  [3] = '{0, 0, 0};
    int     m_hz  [3] = '{0, 0, 0};
    longint m_cnt [3][3];

    logic [4:0]  g_en  [3];
    logic [1:0]  g_hz  [3];
    logic [31:0] g_cnt [3][3];

    task automatic cmp(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    function automatic bit load_use();
        return ex_MemRead && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
    endfunction

    // 0 reset, 1 freeze, 2 branch, 3 bubble, 4 normal
    function automatic int classify(input int i);
        if (!rst)                          return 0;
        if (dmem_busy)                     return 1;
        if (branch_taken)                  return 2;
        if (owed[i] > 0 || load_use())     return 3;
        return 4;
    endfunction

    function automatic logic [4:0] exp_en(input int c);
        case (c)
            0:       return 5'b00011;
            1:       return 5'b00000;
            2:       return 5'b11111;
            3:       return 5'b00101;
            default: return 5'b11100;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int c;
            int nw;
            longint mx;
            c  = classify(i);
            mx = (64'sd1 <<< w_of[i]) - 1;
            if (c == 0) begin
                owed[i] <= 0;
                m_hz[i] <= 0;
                for (int k = 0; k < 3; k++) m_cnt[i][k] <= 0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    bit ev;
                    ev = (k == 0 && c == 3) || (k == 1 && c == 2) || (k == 2 && c == 1);
                    if (cnt_clr)                   m_cnt[i][k] <= 0;
                    else if (ev && m_cnt[i][k] < mx) m_cnt[i][k] <= m_cnt[i][k] + 1;
                end
                case (c)
                    1: m_hz[i] <= 2;
                    2: begin owed[i] <= 0; m_hz[i] <= 0; end
                    3: begin
                        nw = (owed[i] == 0) ? lu_of[i] - 1 : owed[i] - 1;
                        owed[i] <= nw;
                        m_hz[i] <= (nw > 0) ? 1 : 0;
                    end
                    default: m_hz[i] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            g_en[0] = {pcw_a, ifw_a, idw_a, iff_a, idf_a};
            g_en[1] = {pcw_b, ifw_b, idw_b, iff_b, idf_b};
            g_en[2] = {pcw_c, ifw_c, idw_c, iff_c, idf_c};
            g_hz[0] = hz_a; g_hz[1] = hz_b; g_hz[2] = hz_c;
            g_cnt[0][0] = sc_a; g_cnt[0][1] = fc_a; g_cnt[0][2] = zc_a;
            g_cnt[1][0] = sc_b; g_cnt[1][1] = fc_b; g_cnt[1][2] = zc_b;
            g_cnt[2][0] = {28'd0, sc_c}; g_cnt[2][1] = {28'd0, fc_c}; g_cnt[2][2] = {28'd0, zc_c};
            for (int i = 0; i < 3; i++) begin
                cmp("enables_flushes", i, 64'(g_en[i]), 64'(exp_en(classify(i))));
                cmp("hz_state", i, 64'(g_hz[i]), 64'(m_hz[i]));
                cmp("stall_cnt", i, 64'(g_cnt[i][0]), 64'(m_cnt[i][0]));
                cmp("flush_cnt", i, 64'(g_cnt[i][1]), 64'(m_cnt[i][1]));
                cmp("freeze_cnt", i, 64'(g_cnt[i][2]), 64'(m_cnt[i][2]));
            end
        end
    end

    task automatic set_in(input bit r, input bit busy, input bit br, input bit mr,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input bit u1, input bit u2, input bit clr);
        rst = r; dmem_busy = busy; branch_taken = br; ex_MemRead = mr; ex_rd = rd;
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2; cnt_clr = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic hazard();
        set_in(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++) m_cnt[i][k] = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk_en = 1'b1;
        step();
        cmp("rst_hz", 1, 64'(hz_b), 64'd0);
        cmp("rst_stall", 1, 64'(sc_b), 64'd0);
        cmp("rst_pcw", 1, 64'(pcw_b), 64'd0);
        cmp("rst_idf", 1, 64'(idf_b), 64'd1);

        idle(); step();
        // Single load-use hazard, then EX holds the bubble.
        hazard(); #1;
        cmp("lu_pcw", 1, 64'(pcw_b), 64'd0);
        step();
        cmp("lu_hz1", 1, 64'(hz_b), 64'd1);
        cmp("lu1_stall", 0, 64'(sc_a), 64'd1);
        idle(); #1;
        cmp("lu1_resume", 0, 64'(pcw_a), 64'd1);
        cmp("lu3_still", 1, 64'(pcw_b), 64'd0);
        step();
        cmp("lu_hz2", 1, 64'(hz_b), 64'd1);
        step();
        cmp("lu_hz3", 1, 64'(hz_b), 64'd0);
        cmp("lu3_stall", 1, 64'(sc_b), 64'd3);
        cmp("lu2_stall", 2, 64'(sc_c), 64'd2);
        cmp("lu1_stall_end", 0, 64'(sc_a), 64'd1);

        // No stall for x0 or an unused matching source.
        set_in(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0); #1;
        cmp("x0_nostall", 1, 64'(pcw_b), 64'd1);
        step();
        set_in(1, 0, 0, 1, 5'd5, 5'd5, 5'd6, 0, 1, 0); #1;
        cmp("unused_nostall", 1, 64'(pcw_b), 64'd1);
        step();
        cmp("nostall_cnt", 1, 64'(sc_b), 64'd3);

        // Branch beats load-use; branch aborts a stall in progress.
        set_in(1, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0); #1;
        cmp("br_flushes", 1, 64'({pcw_b, iff_b, idf_b}), 64'b111);
        step();
        cmp("br_flush_cnt", 1, 64'(fc_b), 64'd1);
        cmp("br_stall_cnt", 1, 64'(sc_b), 64'd3);
        hazard(); step();
        set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); step();
        cmp("abort_hz", 1, 64'(hz_b), 64'd0);
        cmp("abort_stall", 1, 64'(sc_b), 64'd4);
        cmp("abort_flush", 1, 64'(fc_b), 64'd2);
        idle(); #1;
        cmp("abort_run", 1, 64'(pcw_b), 64'd1);
        step();

        // Freeze in the middle of a three-bubble stall.
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
        cmp("clr_stall", 1, 64'(sc_b), 64'd0);
        hazard(); step();
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();
        cmp("frz_hz", 1, 64'(hz_b), 64'd2);
        idle(); #1;
        cmp("frz_resume", 1, 64'({pcw_b, idw_b, idf_b}), 64'b011);
        step(); step();
        cmp("frz_hz_end", 1, 64'(hz_b), 64'd0);
        cmp("frz_stall", 1, 64'(sc_b), 64'd3);
        cmp("frz_cnt", 1, 64'(zc_b), 64'd4);
        step();

        // Reset during freeze, clear vs increment, saturation.
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        cmp("frz2_hz", 1, 64'(hz_b), 64'd2);
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        cmp("rstfrz_hz", 1, 64'(hz_b), 64'd0);
        cmp("rstfrz_cnt", 1, 64'(zc_b), 64'd0);
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 1); step();
        cmp("clr_wins", 1, 64'(zc_b), 64'd0);
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (20) step();
        cmp("sat_c", 2, 64'(zc_c), 64'd15);
        cmp("nosat_b", 1, 64'(zc_b), 64'd20);
        idle(); step();

        // Random traffic; small register indices make collisions frequent.
        repeat (3000) begin
            set_in($urandom_range(0, 63) != 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
            step();
        end
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
